// File: rtl/instr_fetch_unit_pkg.sv
// Shared control-word layout, PC-source encodings, instruction field slices and opcodes
// used by the fetch unit and the controller FSM.
package instr_fetch_unit_pkg;

  localparam int CTRL_W = 16;

  localparam int CB_PCWRITECOND = 15;
  localparam int CB_PCWRITE     = 14;
  localparam int CB_IORD        = 13;
  localparam int CB_MEMREAD     = 12;
  localparam int CB_MEMWRITE    = 11;
  localparam int CB_MEMTOREG    = 10;
  localparam int CB_IRWRITE     = 9;
  localparam int CB_PCSRC_HI    = 8;
  localparam int CB_PCSRC_LO    = 7;
  localparam int CB_ALUOP_HI    = 6;
  localparam int CB_ALUOP_LO    = 5;
  localparam int CB_ALUSRCB_HI  = 4;
  localparam int CB_ALUSRCB_LO  = 3;
  localparam int CB_ALUSRCA     = 2;
  localparam int CB_REGWRITE    = 1;
  localparam int CB_REGDST      = 0;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  typedef enum logic [1:0] {
    PCSRC_ALU     = 2'b00,
    PCSRC_ALUOUT  = 2'b01,
    PCSRC_JUMP    = 2'b10,
    PCSRC_ILLEGAL = 2'b11
  } pcsrc_e;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int R1_HI    = 25;
  localparam int R1_LO    = 21;
  localparam int R2_HI    = 20;
  localparam int R2_LO    = 16;
  localparam int R3_HI    = 15;
  localparam int R3_LO    = 11;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int IMM_W    = 16;
  localparam int JADDR_HI = 25;

  localparam logic [5:0] OP_NOOP = 6'b000000;
  localparam logic [5:0] OP_JUMP = 6'b000001;

  function automatic ctrl_t to_ctrl(input logic [CTRL_W-1:0] w);
    return ctrl_t'(w);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Datapath-side bundle of the fetch unit: control word and ALU/memory inputs in,
// address, architectural registers and decoded instruction fields out.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [5:0]        opcode;
  logic [4:0]        r1_idx;
  logic [4:0]        r2_idx;
  logic [4:0]        r3_idx;
  logic [DATA_W-1:0] imm_se;
  logic [DATA_W-1:0] imm_ze;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] alu_out;
  logic [31:0]       instr_count;
  logic              pcsrc_err;

  modport master (
    output ctrl, alu_result, alu_zero, mem_rdata,
    input  mem_addr, pc, ir, opcode, r1_idx, r2_idx, r3_idx,
           imm_se, imm_ze, mdr, alu_out, instr_count, pcsrc_err
  );

  modport slave (
    input  ctrl, alu_result, alu_zero, mem_rdata,
    output mem_addr, pc, ir, opcode, r1_idx, r2_idx, r3_idx,
           imm_se, imm_ze, mdr, alu_out, instr_count, pcsrc_err
  );

endinterface

// File: rtl/instr_fetch_unit_en_reg.sv
// Generic W-bit register with synchronous active-high reset to RST_VAL and a load enable.
module instr_fetch_unit_en_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch datapath: PC, IR, MDR and ALUOut registers, next-PC selection for
// fetch/branch/jump, memory address mux and instruction field decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.slave bus
);

  ctrl_t             c;
  pcsrc_e            pc_src;
  logic              pc_we;
  logic              pc_en;
  logic [DATA_W-1:0] pc_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [31:0]       instr_count_d;
  logic [31:0]       instr_count_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] alu_out_q;
  logic              pcsrc_err_d;
  logic              pcsrc_err_q;

  assign c      = to_ctrl(bus.ctrl);
  assign pc_src = pcsrc_e'(c.pc_source);

  // BNE semantics: conditional write fires when the compare did NOT produce zero.
  assign pc_we = c.pc_write | (c.pc_write_cond & ~bus.alu_zero);

  always_comb begin
    pc_d        = pc_q;
    pc_en       = 1'b0;
    pcsrc_err_d = pcsrc_err_q;
    if (pc_we) begin
      case (pc_src)
        PCSRC_ALU: begin
          pc_d  = bus.alu_result;
          pc_en = 1'b1;
        end
        PCSRC_ALUOUT: begin
          pc_d  = alu_out_q;
          pc_en = 1'b1;
        end
        PCSRC_JUMP: begin
          pc_d  = {pc_q[DATA_W-1:JADDR_HI+1], ir_q[JADDR_HI:0]};
          pc_en = 1'b1;
        end
        default: pcsrc_err_d = 1'b1;
      endcase
    end
  end

  assign instr_count_d = instr_count_q + 32'd1;

  instr_fetch_unit_en_reg #(.W(DATA_W), .RST_VAL(PC_RESET)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (pc_en),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  instr_fetch_unit_en_reg #(.W(DATA_W), .RST_VAL('0)) u_ir_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (c.ir_write),
    .d_i   (bus.mem_rdata),
    .q_o   (ir_q)
  );

  instr_fetch_unit_en_reg #(.W(32), .RST_VAL(32'd0)) u_icount_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (c.ir_write),
    .d_i   (instr_count_d),
    .q_o   (instr_count_q)
  );

  // ALUOut must capture every cycle so the decode-cycle branch target survives one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdr_q       <= '0;
      alu_out_q   <= '0;
      pcsrc_err_q <= 1'b0;
    end else begin
      mdr_q       <= bus.mem_rdata;
      alu_out_q   <= bus.alu_result;
      pcsrc_err_q <= pcsrc_err_d;
    end
  end

  assign bus.mem_addr    = c.iord ? alu_out_q : pc_q;
  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.opcode      = ir_q[OPC_HI:OPC_LO];
  assign bus.r1_idx      = ir_q[R1_HI:R1_LO];
  assign bus.r2_idx      = ir_q[R2_HI:R2_LO];
  assign bus.r3_idx      = ir_q[R3_HI:R3_LO];
  assign bus.imm_se      = {{(DATA_W-IMM_W){ir_q[IMM_HI]}}, ir_q[IMM_HI:IMM_LO]};
  assign bus.imm_ze      = {{(DATA_W-IMM_W){1'b0}}, ir_q[IMM_HI:IMM_LO]};
  assign bus.mdr         = mdr_q;
  assign bus.alu_out     = alu_out_q;
  assign bus.instr_count = instr_count_q;
  assign bus.pcsrc_err   = pcsrc_err_q;

  logic unused_ctrl;
  assign unused_ctrl = ^{c.mem_read, c.mem_write, c.memto_reg, c.alu_op,
                         c.alu_src_b, c.alu_src_a, c.reg_write, c.reg_dst};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector table for the fetch/branch/jump/LWI/illegal/reset sequences, followed
// by random control words checked against a behavioural model of the fetch unit.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instr_fetch_unit_if #(.DATA_W(32)) bus ();

  instr_fetch_unit #(.DATA_W(32), .PC_RESET(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] ctrl;
    logic [31:0] alu;
    logic        z;
    logic [31:0] rd;
    logic        chk_addr;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] ao;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic [15:0] ctrl, input logic [31:0] alu,
                              input logic z, input logic [31:0] rd, input logic chk_addr,
                              input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] ir,
                              input logic [31:0] mdr, input logic [31:0] ao, input logic [31:0] cnt,
                              input logic err);
    vec_t v;
    v.rst = rst; v.ctrl = ctrl; v.alu = alu; v.z = z; v.rd = rd;
    v.chk_addr = chk_addr; v.addr = addr; v.pc = pc; v.ir = ir;
    v.mdr = mdr; v.ao = ao; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [15:0] ctrl, input logic [31:0] alu,
                       input logic z, input logic [31:0] rd);
    reset          = rst;
    bus.ctrl       = ctrl;
    bus.alu_result = alu;
    bus.alu_zero   = z;
    bus.mem_rdata  = rd;
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_ir, m_mdr, m_ao, m_cnt;
  logic        m_err;

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b1, 16'h0000, 32'h0, 1'b0, 32'h0);

    // Fetch = PCWrite|MemRead|IRWrite|ALUSrcB=01 ; decode = ALUSrcB=11 ;
    // BNE = PCWriteCond|PCSource=01|ALUOp=01|ALUSrcA ; jump = PCWrite|PCSource=10 ;
    // LWI access = IorD|MemRead ; illegal = PCWrite|PCSource=11.
    //             rst   ctrl      alu            z     rdata          ca    addr          pc             ir             mdr            ao             cnt   err
    vecs[0]  = mk(1'b1, 16'h0000, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         32'h0,         32'd0, 1'b0);
    vecs[1]  = mk(1'b1, 16'h0000, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         32'h0,         32'd0, 1'b0);
    vecs[2]  = mk(1'b0, 16'h5208, 32'h1,         1'b0, 32'h4822_0000, 1'b1, 32'h0,        32'h1,         32'h4822_0000, 32'h4822_0000, 32'h1,         32'd1, 1'b0);
    vecs[3]  = mk(1'b0, 16'h0018, 32'h10,        1'b0, 32'h0,         1'b1, 32'h1,        32'h1,         32'h4822_0000, 32'h0,         32'h10,        32'd1, 1'b0);
    vecs[4]  = mk(1'b0, 16'h80A4, 32'h55,        1'b0, 32'h0,         1'b0, 32'h0,        32'h10,        32'h4822_0000, 32'h0,         32'h55,        32'd1, 1'b0);
    vecs[5]  = mk(1'b0, 16'h0018, 32'h30,        1'b0, 32'h0,         1'b0, 32'h0,        32'h10,        32'h4822_0000, 32'h0,         32'h30,        32'd1, 1'b0);
    vecs[6]  = mk(1'b0, 16'h80A4, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,        32'h10,        32'h4822_0000, 32'h0,         32'h0,         32'd1, 1'b0);
    vecs[7]  = mk(1'b0, 16'hC000, 32'h11,        1'b1, 32'h0,         1'b0, 32'h0,        32'h11,        32'h4822_0000, 32'h0,         32'h11,        32'd1, 1'b0);
    vecs[8]  = mk(1'b0, 16'h5208, 32'h0400_0005, 1'b0, 32'h0400_0123, 1'b1, 32'h11,       32'h0400_0005, 32'h0400_0123, 32'h0400_0123, 32'h0400_0005, 32'd2, 1'b0);
    vecs[9]  = mk(1'b0, 16'h4100, 32'hAAAA,      1'b0, 32'h0,         1'b0, 32'h0,        32'h0400_0123, 32'h0400_0123, 32'h0,         32'hAAAA,      32'd2, 1'b0);
    vecs[10] = mk(1'b0, 16'h0000, 32'h20,        1'b0, 32'h0,         1'b0, 32'h0,        32'h0400_0123, 32'h0400_0123, 32'h0,         32'h20,        32'd2, 1'b0);
    vecs[11] = mk(1'b0, 16'h3000, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 32'h20,       32'h0400_0123, 32'h0400_0123, 32'hDEAD_BEEF, 32'h0,         32'd2, 1'b0);
    vecs[12] = mk(1'b0, 16'h4180, 32'h77,        1'b0, 32'h0,         1'b0, 32'h0,        32'h0400_0123, 32'h0400_0123, 32'h0,         32'h77,        32'd2, 1'b1);
    vecs[13] = mk(1'b0, 16'h0000, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0400_0123, 32'h0400_0123, 32'h0400_0123, 32'h0,        32'h0,         32'd2, 1'b1);
    vecs[14] = mk(1'b1, 16'h5208, 32'h5,         1'b0, 32'h1234_5678, 1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         32'h0,         32'd0, 1'b0);

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].rst, vecs[k].ctrl, vecs[k].alu, vecs[k].z, vecs[k].rd);
      #1;
      if (vecs[k].chk_addr) chk("tbl_mem_addr", k, bus.mem_addr, vecs[k].addr);
      @(posedge clk);
      #1;
      chk("tbl_pc", k, bus.pc, vecs[k].pc);
      chk("tbl_ir", k, bus.ir, vecs[k].ir);
      chk("tbl_opcode", k, 32'(bus.opcode), 32'(vecs[k].ir[31:26]));
      chk("tbl_r1", k, 32'(bus.r1_idx), 32'(vecs[k].ir[25:21]));
      chk("tbl_mdr", k, bus.mdr, vecs[k].mdr);
      chk("tbl_alu_out", k, bus.alu_out, vecs[k].ao);
      chk("tbl_count", k, bus.instr_count, vecs[k].cnt);
      chk("tbl_err", k, 32'(bus.pcsrc_err), 32'(vecs[k].err));
    end

    // Hand sequence: immediate extension of a negative immediate.
    drive(1'b0, 16'h0200, 32'h0, 1'b0, 32'h1234_8001);
    @(posedge clk);
    #1;
    chk("seq_imm_se", 0, bus.imm_se, 32'hFFFF_8001);
    chk("seq_imm_ze", 0, bus.imm_ze, 32'h0000_8001);
    chk("seq_r2", 0, 32'(bus.r2_idx), 32'd20);
    chk("seq_r3", 0, 32'(bus.r3_idx), 32'd16);
    chk("seq_count", 0, bus.instr_count, 32'd1);

    // Random phase: start from a known reset state.
    drive(1'b1, 16'h0000, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_ao = 32'h0; m_cnt = 32'd0; m_err = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic        r_rst;
      logic [15:0] r_ctrl;
      logic [31:0] r_alu;
      logic        r_z;
      logic [31:0] r_rd;
      logic        take;
      logic [1:0]  src;
      r_rst  = ($urandom_range(0, 39) == 0);
      r_ctrl = 16'($urandom);
      r_alu  = $urandom;
      r_z    = 1'($urandom_range(0, 1));
      r_rd   = $urandom;
      drive(r_rst, r_ctrl, r_alu, r_z, r_rd);
      #1;
      chk("rnd_mem_addr", i, bus.mem_addr, r_ctrl[13] ? m_ao : m_pc);
      chk("rnd_opcode", i, 32'(bus.opcode), m_ir >> 26);
      chk("rnd_imm_se", i, bus.imm_se, 32'($signed(m_ir[15:0])));
      @(posedge clk);
      #1;
      if (r_rst) begin
        m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_ao = 32'h0; m_cnt = 32'd0; m_err = 1'b0;
      end else begin
        take = r_ctrl[14] || (r_ctrl[15] && !r_z);
        src  = r_ctrl[8:7];
        if (take) begin
          if (src == 2'd0)      m_pc = r_alu;
          else if (src == 2'd1) m_pc = m_ao;
          else if (src == 2'd2) m_pc = (m_pc & 32'hFC00_0000) | (m_ir & 32'h03FF_FFFF);
          else                  m_err = 1'b1;
        end
        if (r_ctrl[9]) begin
          m_ir  = r_rd;
          m_cnt = m_cnt + 32'd1;
        end
        m_mdr = r_rd;
        m_ao  = r_alu;
      end
      chk("rnd_pc", i, bus.pc, m_pc);
      chk("rnd_ir", i, bus.ir, m_ir);
      chk("rnd_mdr", i, bus.mdr, m_mdr);
      chk("rnd_alu_out", i, bus.alu_out, m_ao);
      chk("rnd_count", i, bus.instr_count, m_cnt);
      chk("rnd_err", i, 32'(bus.pcsrc_err), 32'(m_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Holds the program counter, instruction register, memory data register and ALU output register of the multicycle datapath. Sits directly upstream of the controller FSM: it consumes the controller's 16-bit control word and feeds the instruction opcode back as the FSM input. It also generates the memory address and the next-PC value for fetch, branch and jump.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC value loaded on reset.
- `DATA_W`, default 32: width of PC, IR, MDR, ALUOut and memory data.
- `clk`, input, 1: single clock; all registers update on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `ctrl`, input, 16: controller output word.
  - [15] PCWriteCond, [14] PCWrite, [13] IorD, [12] MemRead, [11] MemWrite, [10] MemtoReg, [9] IRWrite.
  - [8:7] PCSource, [6:5] ALUOp, [4:3] ALUSrcB, [2] ALUSrcA, [1] RegWrite, [0] RegDst.
- `alu_result`, input, DATA_W: combinational ALU output for the current cycle.
- `alu_zero`, input, 1: ALU zero flag for the current cycle.
- `mem_rdata`, input, DATA_W: asynchronous memory read data, valid in the same cycle as the address.
- `mem_addr`, output, DATA_W: IorD ? alu_out : pc.
- `pc`, output, DATA_W: current PC (word address).
- `ir`, output, DATA_W: instruction register.
- `opcode`, output, 6: ir[31:26], wired to the controller input.
- `r1_idx`, `r2_idx`, `r3_idx`, output, 5 each: ir[25:21], ir[20:16], ir[15:11].
- `imm_se`, `imm_ze`, output, DATA_W: ir[15:0] sign-extended and zero-extended.
- `mdr`, output, DATA_W: memory data register.
- `alu_out`, output, DATA_W: registered ALU result.
- `instr_count`, output, 32: count of instructions fetched.
- `pcsrc_err`, output, 1: sticky flag for an illegal PCSource.

## Operation
- **PC write enable:** `pc_we = PCWrite | (PCWriteCond & ~alu_zero)`. This implements BNE: the branch is taken when the operands differ.
- **PC source (only applied when pc_we = 1):**
  - 00: alu_result (PC+1 during fetch).
  - 01: alu_out (branch target computed during decode).
  - 10: {pc[31:26], ir[25:0]} (jump).
  - 11: illegal. PC holds its value and `pcsrc_err` sets; it clears only on reset.
- **IR:** loads mem_rdata when IRWrite = 1, otherwise holds.
- **instr_count:** increments by 1 on every IRWrite cycle. Wraps 2^32-1 → 0.
- **MDR and ALUOut:** load mem_rdata and alu_result every cycle, unconditionally.
- **Field outputs** (`opcode`, indices, `imm_se`, `imm_ze`): purely combinational from `ir`.
- **Address:** `mem_addr` is combinational from `ctrl[13]`, `pc` and `alu_out`.
- **Word addressing:** the PC increments by 1 per instruction. This block never shifts or aligns addresses.
- **Simultaneous PCWrite and PCWriteCond:** the PC is written (OR semantics).
- **Simultaneous IRWrite and PC write in the same cycle (fetch):** both use pre-edge values. The IR gets the word at the old PC; the PC gets PC+1.
- **Unused bits:** MemRead, MemWrite, MemtoReg, ALUOp, ALUSrc*, RegWrite and RegDst are ignored by this block.

## Timing
- **Reset** (synchronous, takes priority over every enable, including mid-instruction):
  - pc = PC_RESET.
  - ir = 0, so opcode = 000000 (NOOP).
  - mdr = 0, alu_out = 0, instr_count = 0, pcsrc_err = 0.
- **Register latency:** all register outputs change one cycle after the enabling ctrl/data cycle.
- **Combinational outputs:** `mem_addr` and the IR field outputs have zero latency.
- **Opcode timing:** `opcode` is valid from the cycle after fetch, i.e. in the decode cycle, which is when the controller samples it.
- **Branch:** the target is computed into alu_out during decode and consumed during branch completion. `alu_out` must therefore hold the decode-cycle ALU result exactly one cycle later.
- **Handshakes:** none. Memory is single-cycle and the block never stalls.

## Structure
- **Shared package `cpu_pkg`:**
  - Control-word bit positions.
  - PCSource encodings (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP).
  - Instruction field slice constants.
  - Opcode constants shared with the controller.
- **Sub-module `en_reg`:** a parameterized DATA_W register with synchronous reset and enable. It is instantiated for the PC, IR and instruction counter.
- **In-line logic:** MDR and ALUOut are plain always-enabled registers written in this block. The PC mux and `pc_we` logic are also in-line.

## Test plan
- **Reset:** hold reset for 2 cycles, then release.
  - Expect pc = 0, ir = 0, opcode = 0, instr_count = 0, pcsrc_err = 0.
- **Fetch:**
  - Stimulus: ctrl = fetch word (PCWrite, MemRead, IRWrite, ALUSrcB = 01), mem_rdata = 32'h4822_0000, alu_result = 1.
  - Expect next cycle: ir = 32'h4822_0000, opcode = 6'b010010, pc = 1, instr_count = 1.
- **BNE taken, then not taken:**
  - Decode cycle: alu_result = 32'h10, so alu_out = 32'h10.
  - Branch cycle, PCWriteCond = 1 with PCSource = 01, alu_zero = 0: expect pc = 32'h10.
  - Repeat with alu_zero = 1: expect pc unchanged.
- **Jump:**
  - Stimulus: pc = 32'h0400_0005, ir = {6'b000001, 26'h000_0123}, PCWrite = 1, PCSource = 10.
  - Expect pc = 32'h0400_0123.
- **LWI address and MDR:**
  - IorD = 1 with alu_out = 32'h20: expect mem_addr = 32'h20.
  - mem_rdata = 32'hDEAD_BEEF: expect mdr = 32'hDEAD_BEEF next cycle.
- **Illegal PCSource and reset mid-operation:**
  - PCWrite = 1 with PCSource = 11: expect pc held and pcsrc_err = 1.
  - Assert reset in the same cycle as IRWrite: expect ir = 0, instr_count = 0 and pcsrc_err = 0 next cycle.
